// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch front-end signals. The fetch unit itself uses the
//   master modport. The surrounding pipeline, or a testbench, uses the
//   slave modport.
//
//   Groups:
//     imem_addr / imem_data        instruction memory read port
//     stall / flush                pipeline hazard control
//     br_valid / br_kind / br_pc /
//     br_off19 / br_off26 / br_reg redirect request from EX
//     if_id_valid / if_id_instr /
//     if_id_pc / if_id_pc_plus4    IF/ID pipeline register contents
//     fetch_count / squash_count   performance counters
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              stall;
  logic              flush;
  logic              br_valid;
  logic [1:0]        br_kind;
  logic [ADDR_W-1:0] br_pc;
  logic [18:0]       br_off19;
  logic [25:0]       br_off26;
  logic [ADDR_W-1:0] br_reg;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc_plus4;
  logic [31:0]       fetch_count;
  logic [31:0]       squash_count;

  modport master (
    output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           fetch_count, squash_count,
    input  imem_data, stall, flush, br_valid, br_kind, br_pc, br_off19,
           br_off26, br_reg
  );

  modport slave (
    input  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           fetch_count, squash_count,
    output imem_data, stall, flush, br_valid, br_kind, br_pc, br_off19,
           br_off26, br_reg
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. It holds a registered PC and selects the
//   next PC from three sources: a redirect from EX, a stall hold, or a
//   sequential PC+4 step. It also owns the IF/ID pipeline register. The
//   instruction memory is read combinationally at the PC register.
//
//   Optional feature: macro FETCH_UNIT_PERF_EN builds the saturating
//   fetch and squash performance counters. When the macro is undefined,
//   both counter outputs are tied to zero.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    fetch_unit_if.master, which carries the imem port, the hazard
//            controls, the redirect request, the IF/ID outputs and the
//            counters
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);

  // Sign-extend an instruction-word offset and scale it to bytes.
  function automatic logic [ADDR_W-1:0] word_off19(input logic [18:0] off);
    return {{(ADDR_W-21){off[18]}}, off, 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] word_off26(input logic [25:0] off);
    return {{(ADDR_W-28){off[25]}}, off, 2'b00};
  endfunction

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              redirect_s;
  logic              clear_s;
  logic              load_s;
  logic              if_id_valid_r;
  logic [31:0]       if_id_instr_r;
  logic [ADDR_W-1:0] if_id_pc_r;
  logic [ADDR_W-1:0] if_id_pc_plus4_r;

  // Branch target and redirect decode. Kind 11 is reserved and never redirects.
  always_comb begin
    pc_plus4_s = pc_r + PC_STEP;
    redirect_s = 1'b0;
    target_s   = pc_plus4_s;
    case (bus.br_kind)
      2'b00: begin
        redirect_s = bus.br_valid;
        target_s   = bus.br_pc + word_off19(bus.br_off19);
      end
      2'b01: begin
        redirect_s = bus.br_valid;
        target_s   = bus.br_pc + word_off26(bus.br_off26);
      end
      2'b10: begin
        redirect_s = bus.br_valid;
        target_s   = bus.br_reg & ALIGN_MASK;
      end
      default: begin
        redirect_s = 1'b0;
        target_s   = pc_plus4_s;
      end
    endcase
  end

  // Next-PC priority: a redirect beats a stall, and a stall beats the sequential step.
  always_comb begin
    if (redirect_s) begin
      next_pc_s = target_s;
    end else if (bus.stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // IF/ID control. A redirect or flush kills the entry even when stall is set.
  always_comb begin
    clear_s = redirect_s || bus.flush;
    if (clear_s) begin
      load_s = 1'b0;
    end else begin
      load_s = !bus.stall;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // IF/ID pipeline register. Payload fields hold when the entry is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid_r    <= 1'b0;
      if_id_instr_r    <= 32'h0000_0000;
      if_id_pc_r       <= {ADDR_W{1'b0}};
      if_id_pc_plus4_r <= {ADDR_W{1'b0}};
    end else if (clear_s) begin
      if_id_valid_r    <= 1'b0;
    end else if (load_s) begin
      if_id_valid_r    <= 1'b1;
      if_id_instr_r    <= bus.imem_data;
      if_id_pc_r       <= pc_r;
      if_id_pc_plus4_r <= pc_plus4_s;
    end else begin
      if_id_valid_r    <= if_id_valid_r;
    end
  end

  assign bus.imem_addr      = pc_r;
  assign bus.if_id_valid    = if_id_valid_r;
  assign bus.if_id_instr    = if_id_instr_r;
  assign bus.if_id_pc       = if_id_pc_r;
  assign bus.if_id_pc_plus4 = if_id_pc_plus4_r;

`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] squash_cnt_r;
  logic        squash_s;

  // A squash only counts when a live entry is thrown away.
  always_comb begin
    if (clear_s) begin
      squash_s = if_id_valid_r;
    end else begin
      squash_s = 1'b0;
    end
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r  <= 32'h0000_0000;
      squash_cnt_r <= 32'h0000_0000;
    end else begin
      if (load_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if (squash_s && (squash_cnt_r != 32'hFFFF_FFFF)) begin
        squash_cnt_r <= squash_cnt_r + 32'd1;
      end else begin
        squash_cnt_r <= squash_cnt_r;
      end
    end
  end

  assign bus.fetch_count  = fetch_cnt_r;
  assign bus.squash_count = squash_cnt_r;
`else
  assign bus.fetch_count  = 32'h0000_0000;
  assign bus.squash_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. There are two instances:
//     u_dut64  ADDR_W=64, RESET_PC=0, which receives the directed and
//              random stimulus
//     u_dut32  ADDR_W=32, RESET_PC=0xFFFF_FFF0, which free-runs to show
//              the PC wrapping through zero
//   Expected values come from a behavioural model of the fetch rules.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_UNIT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  fetch_unit_if #(.ADDR_W(64)) bus64 ();
  fetch_unit_if #(.ADDR_W(32)) bus32 ();

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF0)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  // Instruction memory contents: an arbitrary hash of the address.
  function automatic logic [31:0] imem_fn(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  assign bus64.imem_data = imem_fn(bus64.imem_addr);
  assign bus32.imem_data = imem_fn({32'h0, bus32.imem_addr});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] m_pc, m_ipc, m_ipc4;
  logic        m_valid;
  logic [31:0] m_instr, m_fetch, m_squash;

  task automatic m_reset();
    m_pc = 64'h0; m_valid = 1'b0; m_instr = 32'h0;
    m_ipc = 64'h0; m_ipc4 = 64'h0; m_fetch = 32'h0; m_squash = 32'h0;
  endtask

  // One clock edge of the fetch rules, evaluated with integer arithmetic.
  task automatic m_step(input bit st, input bit fl, input bit bv, input logic [1:0] k,
                        input logic [63:0] bpc, input logic [18:0] o19,
                        input logic [25:0] o26, input logic [63:0] breg);
    bit          redir;
    logic [63:0] tgt;
    logic [31:0] fetched;
    redir   = bv && (k != 2'd3);
    fetched = imem_fn(m_pc);
    tgt     = 64'h0;
    if (k == 2'd0) tgt = bpc + 64'(longint'($signed(o19)) * 4);
    if (k == 2'd1) tgt = bpc + 64'(longint'($signed(o26)) * 4);
    if (k == 2'd2) tgt = breg & ~64'd3;
    if (redir || fl) begin
      if (m_valid && m_squash != 32'hFFFF_FFFF) m_squash = m_squash + 32'd1;
      m_valid = 1'b0;
    end else if (!st) begin
      m_valid = 1'b1;
      m_instr = fetched;
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 64'd4;
      if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 32'd1;
    end
    if (redir)    m_pc = tgt;
    else if (!st) m_pc = m_pc + 64'd4;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("imem_addr", bus64.imem_addr, m_pc);
    chk("if_id_valid", 64'(bus64.if_id_valid), 64'(m_valid));
    if (m_valid) begin
      chk("if_id_instr", 64'(bus64.if_id_instr), 64'(m_instr));
      chk("if_id_pc", bus64.if_id_pc, m_ipc);
      chk("if_id_pc_plus4", bus64.if_id_pc_plus4, m_ipc4);
    end
    chk("fetch_count", 64'(bus64.fetch_count), PERF ? 64'(m_fetch) : 64'h0);
    chk("squash_count", 64'(bus64.squash_count), PERF ? 64'(m_squash) : 64'h0);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic cyc(input bit st, input bit fl, input bit bv, input logic [1:0] k,
                     input logic [63:0] bpc, input logic [18:0] o19,
                     input logic [25:0] o26, input logic [63:0] breg);
    bus64.stall = st; bus64.flush = fl; bus64.br_valid = bv; bus64.br_kind = k;
    bus64.br_pc = bpc; bus64.br_off19 = o19; bus64.br_off26 = o26; bus64.br_reg = breg;
    @(posedge clk);
    #1;
    m_step(st, fl, bv, k, bpc, o19, o26, breg);
    chk_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 19'h0, 26'h0, 64'h0);
  endtask

  // Asynchronous reset pulse between edges, with the state checked before the next edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_imem_addr", bus64.imem_addr, 64'h0);
    chk("rst_valid", 64'(bus64.if_id_valid), 64'h0);
    chk("rst_fetch_count", 64'(bus64.fetch_count), 64'h0);
    chk("rst_squash_count", 64'(bus64.squash_count), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  // Directed steps followed by a randomized run.
  initial begin
    tests = 0; failed = 0;
    rst_n = 1'b0;
    bus64.stall = 1'b0; bus64.flush = 1'b0; bus64.br_valid = 1'b0; bus64.br_kind = 2'd0;
    bus64.br_pc = 64'h0; bus64.br_off19 = 19'h0; bus64.br_off26 = 26'h0; bus64.br_reg = 64'h0;
    bus32.stall = 1'b0; bus32.flush = 1'b0; bus32.br_valid = 1'b0; bus32.br_kind = 2'd0;
    bus32.br_pc = 32'h0; bus32.br_off19 = 19'h0; bus32.br_off26 = 26'h0; bus32.br_reg = 32'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", bus64.imem_addr, 64'h0);
    chk("reset_valid", 64'(bus64.if_id_valid), 64'h0);
    chk("reset_instr", 64'(bus64.if_id_instr), 64'h0);
    chk("reset_if_id_pc", bus64.if_id_pc, 64'h0);
    chk("reset_if_id_pc4", bus64.if_id_pc_plus4, 64'h0);
    chk("reset_fetch", 64'(bus64.fetch_count), 64'h0);
    chk("reset_squash", 64'(bus64.squash_count), 64'h0);
    chk("reset_pc32", 64'(bus32.imem_addr), 64'hFFFF_FFF0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running from RESET_PC.
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("seq_if_id_pc", bus64.if_id_pc, 64'(i * 4));
      chk("seq_valid", 64'(bus64.if_id_valid), 64'h1);
    end
    // 32-bit instance wraps: PC 0xFFFF_FFFC -> 0.
    chk("wrap_pc32", 64'(bus32.imem_addr), 64'h0);
    chk("wrap_if_id_pc32", 64'(bus32.if_id_pc), 64'hFFFF_FFFC);
    chk("wrap_pc4_32", 64'(bus32.if_id_pc_plus4), 64'h0);

    // Stall for 3 cycles at PC 0x10.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 64'h0, 19'h0, 26'h0, 64'h0);
      chk("stall_pc", bus64.imem_addr, 64'h10);
      chk("stall_if_id_pc", bus64.if_id_pc, 64'hC);
    end
    idle();
    chk("unstall_if_id_pc", bus64.if_id_pc, 64'h10);

    // Conditional branch with an offset of -1 word.
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 64'h40, 19'h7FFFF, 26'h0, 64'h0);
    chk("cb_pc", bus64.imem_addr, 64'h3C);
    chk("cb_bubble", 64'(bus64.if_id_valid), 64'h0);
    idle();
    chk("cb_if_id_pc", bus64.if_id_pc, 64'h3C);
    // Unconditional branch.
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 64'h40, 19'h0, 26'd3, 64'h0);
    chk("b_pc", bus64.imem_addr, 64'h4C);
    idle();
    // Register branch with misaligned low bits.
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 64'h0, 19'h0, 26'h0, 64'h1237);
    chk("br_pc", bus64.imem_addr, 64'h1234);
    idle();
    // Reserved kind is ignored.
    cyc(1'b0, 1'b0, 1'b1, 2'd3, 64'h40, 19'h1, 26'h1, 64'h80);
    chk("kind11_pc", bus64.imem_addr, 64'h123C);
    // Redirect beats stall; stall plus flush holds the PC and kills the entry.
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 64'h200, 19'h0, 26'h3FFFFFE, 64'h0);
    chk("stall_redir_pc", bus64.imem_addr, 64'h1F8);
    idle();
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 64'h0, 19'h0, 26'h0, 64'h0);
    chk("stall_flush_pc", bus64.imem_addr, 64'h1FC);
    chk("stall_flush_valid", 64'(bus64.if_id_valid), 64'h0);

    // Counter scenario: 10 loads and 2 squashes of live entries.
    @(posedge clk);
    #1;
    pulse_reset();
    for (int i = 0; i < 9; i++) idle();
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 64'h0, 19'h0, 26'h0, 64'h0);
    idle();
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 64'h0, 19'h0, 26'h0, 64'h100);
    chk("perf_fetch10", 64'(bus64.fetch_count), PERF ? 64'd10 : 64'd0);
    chk("perf_squash2", 64'(bus64.squash_count), PERF ? 64'd2 : 64'd0);

    // Randomized run against the model, with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
          {32'($urandom), 32'($urandom)}, 19'($urandom), 26'($urandom),
          {32'($urandom), 32'($urandom)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the 5-stage pipelined CPU. It replaces the single-cycle program-counter path with a registered PC, next-PC selection for sequential, conditional, unconditional and register branches, stall and flush control, and the IF/ID pipeline register. It drives the instruction memory address and presents a valid-tagged instruction and PC to the decode stage.

## Interface
Parameters:
- ADDR_W, 64, PC and address width (≥ 32)
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- imem_addr  out  ADDR_W  current PC to instruction memory (combinational read)
- imem_data  in  32  instruction at imem_addr, valid same cycle
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  invalidate IF/ID entry
- br_valid  in  1  redirect request from EX
- br_kind  in  2  00 conditional, 01 unconditional, 10 register, 11 reserved (ignored)
- br_pc  in  ADDR_W  PC of the branching instruction
- br_off19  in  19  CB-type offset, instruction words
- br_off26  in  26  B-type offset, instruction words
- br_reg  in  ADDR_W  BR target register value
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_instr  out  32  latched instruction
- if_id_pc  out  ADDR_W  PC of latched instruction
- if_id_pc_plus4  out  ADDR_W  if_id_pc + 4 (for BL link)
- fetch_count  out  32  perf counter, see Configuration
- squash_count  out  32  perf counter, see Configuration

## Operation
- Registers: PC, IF/ID {valid, instr, pc, pc_plus4}.
- Target: kind 00 → br_pc + (sext(br_off19) << 2); 01 → br_pc + (sext(br_off26) << 2); 10 → br_reg with bits [1:0] forced to 0. All arithmetic modulo 2^ADDR_W.
- br_valid with kind 11: treated as no redirect.
- Next-PC priority per edge: redirect (br_valid, kind ≠ 11) > stall (hold) > PC + 4.
- IF/ID update priority: redirect or flush → valid = 0, other fields don't-care (hold) > stall → hold all > load {1, imem_data, PC, PC + 4}.
- Redirect overrides stall for both PC and IF/ID.
- flush with stall: IF/ID cleared, PC held.
- flush without stall or redirect: IF/ID cleared, PC advances to PC + 4 (fetched instruction is discarded).
- PC wrap: all-ones-minus-3 + 4 → 0; no error indication.
- imem_addr = PC register, combinational.

## Timing
- Reset (asynchronous, any time including mid-stall or mid-redirect): PC = RESET_PC, if_id_valid = 0, if_id_instr = 0, if_id_pc = 0, if_id_pc_plus4 = 0, counters = 0.
- First rising edge after rst_n deasserts: IF/ID loads instruction at RESET_PC, valid = 1; PC = RESET_PC + 4.
- Fetch latency: one cycle from imem_addr to if_id_instr.
- Redirect penalty: br_valid sampled at edge N → PC = target after N; IF/ID invalid after N; target instruction valid in IF/ID after N+1.
- All inputs sampled on rising edge only; no combinational path from inputs to outputs except none (imem_addr is registered PC).

## Configuration
- Macro FETCH_UNIT_PERF_EN.
- Defined: fetch_count increments on each edge where IF/ID loads with valid = 1; squash_count increments on each edge where if_id_valid = 1 and the entry is cleared by flush or redirect. Both saturate at 32'hFFFF_FFFF; cleared only by reset.
- Undefined: counter logic not built; both ports tied to 0.

## Test plan
- Reset then 4 free-running cycles, RESET_PC = 0, imem returns PC-indexed words → if_id_pc 0, 4, 8, 12 in successive cycles, valid = 1 from first edge.
- stall held 3 cycles at PC = 0x10 → imem_addr stays 0x10, IF/ID unchanged, resumes with 0x10 loaded after release.
- br_valid, kind 00, br_pc = 0x40, br_off19 = 19'h7FFFF (−1) → PC = 0x3C, IF/ID invalid one cycle, then if_id_pc = 0x3C; kind 01, br_pc = 0x40, br_off26 = 3 → 0x4C; kind 10, br_reg = 0x1237 → 0x1234.
- stall and br_valid in same cycle → redirect taken; stall and flush → PC held, if_id_valid = 0.
- ADDR_W = 32, PC = 0xFFFF_FFFC free-running → next PC 0x0, if_id_pc_plus4 = 0x0.
- FETCH_UNIT_PERF_EN defined: 10 loads, 2 squashes of valid entries → fetch_count = 10, squash_count = 2; rst_n pulse mid-run → both 0, PC = RESET_PC immediately.
